// File: rtl/state_timer.sv
// Per-state millisecond countdown for the train-control FSM.
// Restarts on every FSM state change and reports expiry as pulse + level.
module state_timer #(
    parameter int unsigned TICKS_PER_MS = 50000,
    parameter int unsigned T_WIDTH      = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         present_state,
    input  logic [T_WIDTH-1:0] t,
    input  logic               pause,
    output logic               time_up,
    output logic               expired,
    output logic               busy,
    output logic [T_WIDTH-1:0] remaining_ms
);

    localparam int unsigned PW =
        (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         prev_q, prev_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [T_WIDTH-1:0] rem_q, rem_d;
    logic               time_up_q, time_up_d;
    logic               expired_q, expired_d;
    logic               busy_q, busy_d;

    logic changed;
    logic tick;
    logic last_ms;
    logic expire;

    assign changed = (present_state != prev_q);
    assign tick    = (presc_q == '0);
    assign last_ms = (rem_q == T_WIDTH'(1));
    // A state change on the same edge always wins over expiry.
    assign expire  = (state_q == RUN) && !changed && !pause
                     && tick && last_ms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prev_q    <= 4'b0000;
            presc_q   <= '0;
            rem_q     <= '0;
            time_up_q <= 1'b0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            presc_q   <= presc_d;
            rem_q     <= rem_d;
            time_up_q <= time_up_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = present_state;
        if (changed) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                LOAD: state_d = (t == '0) ? IDLE : RUN;
                RUN:  state_d = expire ? DONE : RUN;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d   = presc_q;
        rem_d     = rem_q;
        time_up_d = 1'b0;
        expired_d = expired_q;
        busy_d    = busy_q;
        if (changed) begin
            rem_d     = '0;
            expired_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rem_d     = '0;
                    expired_d = 1'b0;
                    busy_d    = 1'b0;
                end
                LOAD: begin
                    rem_d     = t;
                    presc_d   = PRE_MAX;
                    expired_d = 1'b0;
                    busy_d    = (t != '0);
                end
                RUN: begin
                    if (!pause) begin
                        if (tick) begin
                            presc_d = PRE_MAX;
                            rem_d   = rem_q - T_WIDTH'(1);
                        end else begin
                            presc_d = presc_q - PW'(1);
                        end
                    end
                    if (expire) begin
                        time_up_d = 1'b1;
                        expired_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
                DONE: begin
                    rem_d     = '0;
                    expired_d = 1'b1;
                    busy_d    = 1'b0;
                end
                default: begin
                    rem_d  = '0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    assign time_up      = time_up_q;
    assign expired      = expired_q;
    assign busy         = busy_q;
    assign remaining_ms = rem_q;

endmodule

// File: tb/tb_state_timer.sv
// Randomised + directed bench for state_timer against an
// elapsed-time model (TICKS_PER_MS = 4 and = 1 instances).
module tb_state_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  psA, psB;
    logic [18:0] tA, tB;
    logic        pzA, pzB;
    logic        tupA, expA, busyA;
    logic        tupB, expB, busyB;
    logic [18:0] remA, remB;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    state_timer #(.TICKS_PER_MS(4), .T_WIDTH(19)) dutA (
        .clk(clk), .rst_n(rst_n),
        .present_state(psA), .t(tA), .pause(pzA),
        .time_up(tupA), .expired(expA),
        .busy(busyA), .remaining_ms(remA)
    );

    state_timer #(.TICKS_PER_MS(1), .T_WIDTH(19)) dutB (
        .clk(clk), .rst_n(rst_n),
        .present_state(psB), .t(tB), .pause(pzB),
        .time_up(tupB), .expired(expB),
        .busy(busyB), .remaining_ms(remB)
    );

    // mode: 0 untimed/idle, 1 settling, 2 counting, 3 expired
    typedef struct {
        int         mode;
        logic [3:0] prev;
        longint     tt;
        longint     el;
        bit         tup;
    } mdl_t;

    mdl_t mA, mB;

    function automatic mdl_t mreset();
        mdl_t m;
        m.mode = 0; m.prev = 4'd0;
        m.tt = 0; m.el = 0; m.tup = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [3:0] ps,
                                   longint tin, bit pz,
                                   longint tpm);
        mdl_t n = m;
        n.tup = 1'b0;
        if (ps != m.prev) begin
            n.mode = 1; n.prev = ps;
            n.tt = 0; n.el = 0;
            return n;
        end
        if (m.mode == 1) begin
            if (tin == 0) n.mode = 0;
            else begin n.mode = 2; n.tt = tin; n.el = 0; end
        end else if (m.mode == 2 && !pz) begin
            n.el = m.el + 1;
            if (n.el == m.tt * tpm) begin
                n.mode = 3; n.tup = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic longint mrem(mdl_t m, longint tpm);
        return (m.mode == 2) ? m.tt - m.el / tpm : 0;
    endfunction

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mA = mreset();
            mB = mreset();
        end else begin
            mA = mstep(mA, psA, longint'(tA), pzA, 4);
            mB = mstep(mB, psB, longint'(tB), pzB, 1);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("A.time_up", 64'(tupA), 64'(mA.tup));
            chk("A.expired", 64'(expA), 64'(mA.mode == 3));
            chk("A.busy", 64'(busyA), 64'(mA.mode == 2));
            chk("A.rem", 64'(remA), 64'(mrem(mA, 4)));
            chk("B.time_up", 64'(tupB), 64'(mB.tup));
            chk("B.expired", 64'(expB), 64'(mB.mode == 3));
            chk("B.busy", 64'(busyB), 64'(mB.mode == 2));
            chk("B.rem", 64'(remB), 64'(mrem(mB, 1)));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        psA = 4'd0; tA = '0; pzA = 1'b0;
        psB = 4'd0; tB = '0; pzB = 1'b0;
        mA = mreset();
        mB = mreset();
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk("rst.busy", 64'(busyA), 64'd0);
        chk("rst.rem", 64'(remA), 64'd0);

        // basic count, t=3 at 4 ticks/ms
        psA = 4'd3; tA = 19'd3;
        tick(1);
        chk("basic.load_busy", 64'(busyA), 64'd0);
        tick(1);
        chk("basic.busy", 64'(busyA), 64'd1);
        chk("basic.rem3", 64'(remA), 64'd3);
        tick(4);
        chk("basic.rem2", 64'(remA), 64'd2);
        tick(4);
        chk("basic.rem1", 64'(remA), 64'd1);
        tick(3);
        chk("basic.early", 64'(tupA), 64'd0);
        tick(1);
        chk("basic.tup", 64'(tupA), 64'd1);
        chk("basic.exp", 64'(expA), 64'd1);
        chk("basic.idle", 64'(busyA), 64'd0);
        chk("basic.rem0", 64'(remA), 64'd0);
        tick(1);
        chk("basic.pulse", 64'(tupA), 64'd0);
        chk("basic.hold", 64'(expA), 64'd1);

        // untimed state
        psA = 4'd7; tA = 19'd0;
        tick(1);
        chk("untimed.exp", 64'(expA), 64'd0);
        tick(6);
        chk("untimed.busy", 64'(busyA), 64'd0);
        chk("untimed.rem", 64'(remA), 64'd0);

        // abort at remaining 2
        psA = 4'd5; tA = 19'd5;
        tick(2);
        chk("abort.rem5", 64'(remA), 64'd5);
        tick(12);
        chk("abort.rem2", 64'(remA), 64'd2);
        psA = 4'd6; tA = 19'd4;
        tick(1);
        chk("abort.rem0", 64'(remA), 64'd0);
        chk("abort.busy", 64'(busyA), 64'd0);
        tick(1);
        chk("abort.rem4", 64'(remA), 64'd4);

        // pause for 10 cycles, t=2
        psA = 4'd1; tA = 19'd2;
        tick(2);
        tick(3);
        pzA = 1'b1;
        tick(10);
        pzA = 1'b0;
        tick(4);
        chk("pause.early", 64'(tupA), 64'd0);
        tick(1);
        chk("pause.tup", 64'(tupA), 64'd1);

        // state change on the expiry edge
        psA = 4'd2; tA = 19'd1;
        tick(2);
        tick(3);
        psA = 4'd9; tA = 19'd3;
        tick(1);
        chk("coll.tup", 64'(tupA), 64'd0);
        chk("coll.exp", 64'(expA), 64'd0);
        tick(1);
        chk("coll.rem3", 64'(remA), 64'd3);

        // pause on the would-be expiry edge
        psA = 4'd11; tA = 19'd1;
        tick(5);
        pzA = 1'b1;
        tick(2);
        chk("pzexp.tup", 64'(tupA), 64'd0);
        chk("pzexp.rem", 64'(remA), 64'd1);
        pzA = 1'b0;
        tick(1);
        chk("pzexp.late", 64'(tupA), 64'd1);

        // 1 tick/ms: short expiry, then all-ones without wrap
        psB = 4'd2; tB = 19'd3;
        tick(2);
        chk("b.rem3", 64'(remB), 64'd3);
        tick(3);
        chk("b.tup", 64'(tupB), 64'd1);
        psB = 4'd1; tB = '1;
        tick(2);
        chk("b.full", 64'(remB), 64'd524287);
        tick(1);
        chk("b.full1", 64'(remB), 64'd524286);
        tick(3000);
        chk("b.full3k", 64'(remB), 64'd521286);

        // asynchronous reset mid-count
        psA = 4'd4; tA = 19'd6;
        tick(5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(busyA), 64'd0);
        chk("arst.rem", 64'(remA), 64'd0);
        chk("arst.exp", 64'(expA), 64'd0);
        chk("arst.remB", 64'(remB), 64'd0);
        psA = 4'd0; psB = 4'd0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("arst.idle", 64'(busyA), 64'd0);

        // randomised traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0)
                psA = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                tA = 19'($urandom_range(0, 6));
            pzA = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0)
                psB = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                tB = 19'($urandom_range(0, 12));
            pzB = ($urandom_range(0, 4) == 0);
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_timer.md
Name: state_timer

Overview:
- Downstream consumer of the per-state time-parameter stage: takes the current FSM state code and the millisecond duration for that state (t, 19 bits).
- Counts that duration in real time and reports expiry back to the train-control FSM as a one-cycle pulse plus a level flag.
- Restarts automatically whenever the FSM state changes.
- Provides remaining time and a pause hold, for display and door/obstacle interlock.

Parameters:
- TICKS_PER_MS, 50000, clk cycles per millisecond (50 MHz board clock); range 1 to 2^20-1.
- T_WIDTH, 19, width of the duration input and remaining-count output.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- present_state  input  4  current FSM state code.
- t  input  T_WIDTH  duration in ms for present_state; 0 means untimed state.
- pause  input  1  high = freeze countdown (prescaler and ms count hold).
- time_up  output  1  one-cycle pulse on expiry.
- expired  output  1  level; high from expiry until next state change or reset.
- busy  output  1  high while counting (RUN), including while paused.
- remaining_ms  output  T_WIDTH  milliseconds left; 0 outside RUN.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces immediately:
  - FSM to IDLE; time_up=0, expired=0, busy=0, remaining_ms=0.
  - prescaler=0; prev_state register=4'b0000.
- All outputs are registered. No combinational path from inputs to outputs.
- State-change detect: at each rising edge, compare present_state with prev_state.
  - On mismatch, go to LOAD from any FSM state and update prev_state.
  - This aborts any count in progress with no time_up pulse, and clears expired and remaining_ms.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: busy=0, remaining_ms=0. Wait for a state change.
- LOAD: exactly one cycle. This absorbs the one-cycle settling of the parameter stage after a state change. At the next edge:
  - Capture t into remaining_ms.
  - Set prescaler=TICKS_PER_MS-1.
  - If t==0, go to IDLE; otherwise go to RUN with busy=1.
  - A further state change seen in LOAD re-enters LOAD.
- RUN:
  - pause=1: hold prescaler and remaining_ms.
  - Otherwise, if prescaler != 0, decrement the prescaler.
  - If prescaler == 0, reload it to TICKS_PER_MS-1 and decrement remaining_ms.
  - When remaining_ms decrements from 1 to 0:
    - Go to DONE and drive time_up=1 for the following cycle only.
    - Set expired=1 and busy=0.
- DONE: hold expired=1 and remaining_ms=0. time_up is 0 after its single pulse. Leave only on a state change (to LOAD).
- Latency: time_up is high in the cycle after edge E_load + t*TICKS_PER_MS, where E_load is the edge that exits LOAD. Pause cycles extend this one-for-one.
- Simultaneous events:
  - State change on the expiry edge: the change wins. Go to LOAD with no time_up and expired=0.
  - pause=1 on the would-be expiry edge: hold, no expiry.
- t is sampled only in LOAD. Changes to t during RUN are ignored.
- t = all-ones (2^19-1) must count fully with no wrap. remaining_ms never underflows.
- TICKS_PER_MS=1: remaining_ms decrements every unpaused RUN cycle.

Test Plan:
- Reset: assert rst_n=0 mid-RUN, asynchronously between edges → all outputs 0 before the next edge. After release with present_state=0 → stays IDLE.
- Basic count (TICKS_PER_MS=4): present_state 0→3 with t=3 → one LOAD cycle, busy=1, remaining_ms=3. Then remaining_ms=2,1,0 every 4 cycles. time_up pulses exactly once, 12 cycles after LOAD exit. expired stays 1, busy=0.
- Untimed state: present_state→7 with t=0 → LOAD then IDLE. time_up, expired and busy never assert.
- Abort: t=5 running, change present_state when remaining_ms=2 → no time_up, expired=0, remaining_ms reloads to the new t after one LOAD cycle.
- Pause: t=2, pause=1 for 10 cycles mid-count → time_up delayed exactly 10 cycles vs. the unpaused run (8 cycles nominal at TICKS_PER_MS=4).
- Collision: state change on the same edge remaining_ms would reach 0 → no time_up pulse; new count starts. Also, with TICKS_PER_MS=1 and t=2^19-1 → expiry after 524287 cycles, no wrap.
